fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, hazard/redirect inputs and IF/ID outputs.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;

    modport master (
        input  stall, redirect, redirect_target, imem_ready, imem_rdata,
        output imem_req, imem_addr, ir_d, pc_d, pc8_d, valid_d
    );

    modport slave (
        output stall, redirect, redirect_target, imem_ready, imem_rdata,
        input  imem_req, imem_addr, ir_d, pc_d, pc8_d, valid_d
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with one-entry skid buffer, delayed-branch redirect and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_skid_ir, w_skid_ir_nxt;
    logic [31:0] r_skid_pc, w_skid_pc_nxt;
    logic        r_pend, w_pend_nxt;
    logic [31:0] r_pend_tgt, w_pend_tgt_nxt;
    logic [31:0] r_ir, w_ir_nxt;
    logic [31:0] r_pc_d, w_pc_d_nxt;
    logic [31:0] r_pc8, w_pc8_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_req;
    logic        w_done;
    logic        w_redir;
    logic [31:0] w_tgt;
    logic [31:0] w_next_addr;

    assign w_req   = reset && (r_state == StFetch);
    assign w_done  = w_req && bus.imem_ready;
    // Redirect from decode only counts when decode is actually advancing.
    assign w_redir = bus.redirect && !bus.stall;
    assign w_tgt   = {bus.redirect_target[31:2], 2'b00};

    always_comb begin
        if (w_redir) begin
            w_next_addr = w_tgt;
        end else if (r_pend) begin
            w_next_addr = r_pend_tgt;
        end else begin
            w_next_addr = r_pc + 32'd4;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_skid_ir_nxt  = r_skid_ir;
        w_skid_pc_nxt  = r_skid_pc;
        w_pend_nxt     = r_pend;
        w_pend_tgt_nxt = r_pend_tgt;
        w_ir_nxt       = r_ir;
        w_pc_d_nxt     = r_pc_d;
        w_pc8_nxt      = r_pc8;
        w_valid_nxt    = r_valid;

        if (w_done) begin
            w_pc_nxt   = w_next_addr;
            w_pend_nxt = 1'b0;
        end else if (w_redir) begin
            w_pend_nxt     = 1'b1;
            w_pend_tgt_nxt = w_tgt;
        end

        unique case (r_state)
            StFetch: begin
                if (w_done && !bus.stall) begin
                    w_ir_nxt    = bus.imem_rdata;
                    w_pc_d_nxt  = r_pc;
                    w_pc8_nxt   = r_pc + 32'd8;
                    w_valid_nxt = 1'b1;
                end else if (w_done) begin
                    w_skid_ir_nxt = bus.imem_rdata;
                    w_skid_pc_nxt = r_pc;
                    w_state_nxt   = StHold;
                end else if (!bus.stall) begin
                    w_ir_nxt    = 32'd0;
                    w_valid_nxt = 1'b0;
                end
            end
            StHold: begin
                if (!bus.stall) begin
                    w_ir_nxt    = r_skid_ir;
                    w_pc_d_nxt  = r_skid_pc;
                    w_pc8_nxt   = r_skid_pc + 32'd8;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = StFetch;
                end
            end
            default: w_state_nxt = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StFetch;
            r_pc       <= RESET_PC;
            r_skid_ir  <= 32'd0;
            r_skid_pc  <= 32'd0;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'd0;
            r_ir       <= 32'd0;
            r_pc_d     <= 32'd0;
            r_pc8      <= 32'd0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_skid_ir  <= w_skid_ir_nxt;
            r_skid_pc  <= w_skid_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_ir       <= w_ir_nxt;
            r_pc_d     <= w_pc_d_nxt;
            r_pc8      <= w_pc8_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.ir_d      = r_ir;
    assign bus.pc_d      = r_pc_d;
    assign bus.pc8_d     = r_pc8;
    assign bus.valid_d   = r_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ 32'hDEAD_0000 as the instruction word.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC(32'h0000_3000)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                          input logic [31:0] pc8, input logic valid);
        check_eq({tag, "_ir"}, bus.ir_d, ir);
        check_eq({tag, "_pc"}, bus.pc_d, pc);
        check_eq({tag, "_pc8"}, bus.pc8_d, pc8);
        check_eq({tag, "_valid"}, {31'd0, bus.valid_d}, {31'd0, valid});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'd0;
        bus.imem_ready = 1'b1;
        #2;
        check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk_if("rst", 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rel_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("rel_addr", bus.imem_addr, 32'h0000_3000);

        // Zero-wait streaming
        step();
        chk_if("s1", 32'hDEAD_3000, 32'h3000, 32'h3008, 1'b1);
        step();
        chk_if("s2", 32'hDEAD_3004, 32'h3004, 32'h300C, 1'b1);
        step();
        chk_if("s3", 32'hDEAD_3008, 32'h3008, 32'h3010, 1'b1);

        // Wait states at 3004
        do_reset();
        step();
        chk_if("w0", 32'hDEAD_3000, 32'h3000, 32'h3008, 1'b1);
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_if("wb", 32'd0, 32'h3000, 32'h3008, 1'b0);
            check_eq("wb_addr", bus.imem_addr, 32'h3004);
        end
        bus.imem_ready = 1'b1;
        step();
        chk_if("w3", 32'hDEAD_3004, 32'h3004, 32'h300C, 1'b1);

        // Stall while 3008 completes -> HOLD
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("h_req", {31'd0, bus.imem_req}, 32'd0);
            chk_if("h", 32'hDEAD_3004, 32'h3004, 32'h300C, 1'b1);
        end
        bus.stall = 1'b0;
        step();
        chk_if("hx", 32'hDEAD_3008, 32'h3008, 32'h3010, 1'b1);
        check_eq("hx_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("hx_addr", bus.imem_addr, 32'h300C);
        step();
        check_eq("h2_pc", bus.pc_d, 32'h300C);

        // Redirect with delay slot 3010, target low bits ignored
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3103;
        step();
        chk_if("r1", 32'hDEAD_3010, 32'h3010, 32'h3018, 1'b1);
        check_eq("r1_addr", bus.imem_addr, 32'h3100);
        bus.redirect = 1'b0;
        step();
        chk_if("r2", 32'hDEAD_3100, 32'h3100, 32'h3108, 1'b1);

        // Redirect under stall is ignored
        bus.imem_ready = 1'b0;
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3400;
        step();
        chk_if("e1", 32'hDEAD_3100, 32'h3100, 32'h3108, 1'b1);
        check_eq("e1_addr", bus.imem_addr, 32'h3104);
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        check_eq("e2_pc", bus.pc_d, 32'h3104);
        check_eq("e2_addr", bus.imem_addr, 32'h3108);

        // Pending redirect overwritten, applied after delay slot
        bus.imem_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3300;
        step();
        check_eq("e3_valid", {31'd0, bus.valid_d}, 32'd0);
        check_eq("e3_addr", bus.imem_addr, 32'h3108);
        bus.redirect_target = 32'h3200;
        step();
        check_eq("e4_addr", bus.imem_addr, 32'h3108);
        bus.redirect = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        chk_if("e5", 32'hDEAD_3108, 32'h3108, 32'h3110, 1'b1);
        check_eq("e5_addr", bus.imem_addr, 32'h3200);

        // Async reset in HOLD
        bus.stall = 1'b1;
        step();
        check_eq("f_req", {31'd0, bus.imem_req}, 32'd0);
        #3;
        reset = 1'b0;
        #1;
        chk_if("f_rst", 32'd0, 32'd0, 32'd0, 1'b0);
        check_eq("f_rst_req", {31'd0, bus.imem_req}, 32'd0);
        bus.stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("f_rel_addr", bus.imem_addr, 32'h3000);
        check_eq("f_rel_req", {31'd0, bus.imem_req}, 32'd1);
        step();
        chk_if("f1", 32'hDEAD_3000, 32'h3000, 32'h3008, 1'b1);

        // Address wrap at top of memory
        bus.redirect = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFF;
        step();
        check_eq("g1_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.redirect = 1'b0;
        step();
        chk_if("g2", 32'h2152_FFFC, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1);
        check_eq("g2_addr", bus.imem_addr, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
